// File: rtl/sent_pkg.sv
// Shared definitions for the SENT transmit frame controller: FSM states,
// pulse-length constants and the CRC-4 (x^4+x^3+x^2+1) table and checksum.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } sent_state_e;

    localparam int SYNC_TICKS  = 56;
    localparam int NIBBLE_BASE = 12;
    localparam logic [3:0] CRC4_SEED = 4'b0101;

    function automatic logic [3:0] crc4_lookup(input logic [3:0] idx);
        logic [3:0] val;
        case (idx)
            4'd0:  val = 4'd0;
            4'd1:  val = 4'd13;
            4'd2:  val = 4'd7;
            4'd3:  val = 4'd10;
            4'd4:  val = 4'd14;
            4'd5:  val = 4'd3;
            4'd6:  val = 4'd9;
            4'd7:  val = 4'd4;
            4'd8:  val = 4'd1;
            4'd9:  val = 4'd12;
            4'd10: val = 4'd6;
            4'd11: val = 4'd11;
            4'd12: val = 4'd15;
            4'd13: val = 4'd2;
            4'd14: val = 4'd8;
            default: val = 4'd5;
        endcase
        return val;
    endfunction

    // D1 sits in [23:20] and is folded in first; the status nibble never enters.
    function automatic logic [3:0] crc4_calc(input logic [23:0] data);
        logic [3:0] cs;
        cs = CRC4_SEED;
        for (int i = 5; i >= 0; i--) begin
            cs = crc4_lookup(cs) ^ data[i*4 +: 4];
        end
        return crc4_lookup(cs);
    endfunction

endpackage

// File: rtl/sent_crc4.sv
// Combinational SENT CRC-4 over the six data nibbles.
module sent_crc4
    import sent_pkg::*;
(
    input  logic [23:0] data_i,
    output logic [3:0]  crc_o
);

    always_comb begin
        crc_o = crc4_calc(data_i);
    end

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame controller: captures a frame, then emits sync, status,
// six data nibbles, CRC and an optional pause pulse, all timed in ticks.
module sent_tx_frame_ctrl
    import sent_pkg::*;
#(
    parameter int LOW_TICKS   = 5,
    parameter int PAUSE_EN    = 1,
    parameter int FRAME_TICKS = 282
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic        tick_en,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  status_nib,
    input  logic [23:0] frame_data,
    output logic        sent_out,
    output logic        busy,
    output logic        frame_done
);

    sent_state_e state_q;
    logic [3:0]  status_q;
    logic [23:0] data_q;
    logic [3:0]  crc_q;
    logic [2:0]  nib_idx_q;
    logic [8:0]  pulse_cnt_q;
    logic [8:0]  elapsed_q;
    logic        sent_out_q;
    logic        busy_q;
    logic        ready_q;
    logic        frame_done_q;

    logic [3:0]  crc_w;
    logic [23:0] data_shift;
    logic [3:0]  nib_sel;
    logic [8:0]  pulse_len;
    logic [8:0]  cnt_inc;
    logic [8:0]  elapsed_inc;
    logic        pulse_end;
    logic        last_pulse;
    sent_state_e adv_state;

    sent_crc4 u_crc (
        .data_i (frame_data),
        .crc_o  (crc_w)
    );

    always_comb begin
        data_shift = data_q << {nib_idx_q, 2'b00};
        case (state_q)
            ST_DATA: nib_sel = data_shift[23:20];
            ST_CRC:  nib_sel = crc_q;
            default: nib_sel = status_q;
        endcase
        pulse_len   = (state_q == ST_SYNC) ? 9'(SYNC_TICKS) : 9'(NIBBLE_BASE) + {5'd0, nib_sel};
        cnt_inc     = pulse_cnt_q + 9'd1;
        elapsed_inc = elapsed_q + 9'd1;
        // The pause has no fixed width: it stretches the frame to FRAME_TICKS.
        pulse_end   = (state_q == ST_PAUSE) ? (elapsed_inc == 9'(FRAME_TICKS))
                                            : (cnt_inc == pulse_len);
        last_pulse  = (state_q == ST_PAUSE) || ((state_q == ST_CRC) && (PAUSE_EN == 0));
        case (state_q)
            ST_SYNC:   adv_state = ST_STATUS;
            ST_STATUS: adv_state = ST_DATA;
            ST_DATA:   adv_state = (nib_idx_q == 3'd5) ? ST_CRC : ST_DATA;
            ST_CRC:    adv_state = ST_PAUSE;
            default:   adv_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q      <= ST_IDLE;
            status_q     <= '0;
            data_q       <= '0;
            crc_q        <= '0;
            nib_idx_q    <= '0;
            pulse_cnt_q  <= '0;
            elapsed_q    <= '0;
            sent_out_q   <= 1'b1;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        status_q <= status_nib;
                        data_q   <= frame_data;
                        crc_q    <= crc_w;
                        state_q  <= ST_ARMED;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    // This tick is the first tick of the sync pulse.
                    if (tick_en) begin
                        state_q     <= ST_SYNC;
                        pulse_cnt_q <= 9'd1;
                        elapsed_q   <= 9'd1;
                        sent_out_q  <= 1'b0;
                    end
                end
                default: begin
                    if (tick_en) begin
                        elapsed_q <= elapsed_inc;
                        if (!pulse_end) begin
                            pulse_cnt_q <= cnt_inc;
                            sent_out_q  <= (cnt_inc > 9'(LOW_TICKS));
                        end else begin
                            pulse_cnt_q <= '0;
                            sent_out_q  <= 1'b1;
                            nib_idx_q   <= (state_q == ST_DATA) ? nib_idx_q + 3'd1 : 3'd0;
                            if (last_pulse) begin
                                state_q      <= ST_IDLE;
                                busy_q       <= 1'b0;
                                ready_q      <= 1'b1;
                                frame_done_q <= 1'b1;
                                elapsed_q    <= '0;
                            end else begin
                                state_q <= adv_state;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign frame_ready = ready_q;
    assign sent_out    = sent_out_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: doc/sent_tx_frame_ctrl.md
SENT_TX_FRAME_CTRL -- requirements
Module: sent_tx_frame_ctrl

Interface
REQ-001 SHALL have parameter LOW_TICKS, default 5: low-phase length of every pulse, in ticks.
REQ-002 SHALL have parameter PAUSE_EN, default 1: 1 appends a pause pulse, 0 omits it.
REQ-003 SHALL have parameter FRAME_TICKS, default 282: total frame length in ticks when PAUSE_EN=1.
REQ-004 SHALL have port clk_tx  in  1  transmit clock.
REQ-005 SHALL have port reset_n_tx  in  1  reset, asynchronous, active-low; clock is clk_tx.
REQ-006 SHALL have port tick_en  in  1  one-cycle strobe per SENT tick, from the tick generator.
REQ-007 SHALL have port frame_valid  in  1  frame request.
REQ-008 SHALL have port frame_ready  out  1  controller can accept a frame.
REQ-009 SHALL have port status_nib  in  4  status/communication nibble.
REQ-010 SHALL have port frame_data  in  24  data nibbles D1..D6, where D1=[23:20] and D6=[3:0].
REQ-011 SHALL have port sent_out  out  1  SENT line level; idle high.
REQ-012 SHALL have port busy  out  1  frame in progress.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL capture status_nib and frame_data when frame_valid && frame_ready; frame_ready SHALL be 1 only in IDLE.
REQ-015 SHALL use states IDLE, ARMED, SYNC, STATUS, DATA, CRC, PAUSE.
- Transitions: IDLE -> ARMED on capture; ARMED -> SYNC on next tick_en; SYNC -> STATUS -> DATA (x6) -> CRC -> PAUSE (or -> IDLE if PAUSE_EN=0); PAUSE -> IDLE.
REQ-016 SHALL advance all tick counting only on cycles where tick_en=1; sent_out SHALL update one clk_tx cycle after the sampled tick_en.
- A tick_en coincident with capture SHALL NOT start the frame.
REQ-017 SHALL generate every pulse as LOW_TICKS ticks low followed by high for the remainder of the pulse.
- Sync pulse: 56 ticks.
- Nibble pulse: 12+value ticks (12..27).
REQ-018 SHALL send nibbles in the order status, D1..D6, CRC.
REQ-019 SHALL compute the CRC as follows:
- Start with cs=4'b0101.
- For each of D1..D6: cs = T[cs] XOR nibble.
- Final: crc = T[cs], where T = CRC-4 table for polynomial x^4+x^3+x^2+1 = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
- Status nibble excluded.
REQ-020 SHALL track ticks elapsed since sync start in a 9-bit counter; the pause pulse length SHALL be FRAME_TICKS minus elapsed ticks (minimum 10 with the defaults).
REQ-021 SHALL pulse frame_done for one cycle with the final tick update and return to IDLE that same cycle; sent_out SHALL remain high in IDLE.
REQ-022 SHALL hold busy=1 in all states except IDLE.
REQ-023 SHALL ignore frame_valid while busy; captured data SHALL be stable for the whole frame.
REQ-024 SHALL tolerate irregular tick_en spacing; pulse widths are counted in ticks, not clocks.

Reset
REQ-025 SHALL, on reset_n_tx low at any time including mid-frame, immediately set:
- state=IDLE, sent_out=1, busy=0, frame_done=0, frame_ready=1
- all counters and captured registers = 0.
REQ-026 SHALL start no frame until a new capture after reset release.

Structure
REQ-027 SHALL place the state enum, SYNC_TICKS=56, NIBBLE_BASE=12 and the CRC table/function in shared package sent_pkg.
REQ-028 SHALL implement the CRC in sub-module sent_crc4, which is combinational over the captured data and evaluated at capture.

Verification
REQ-029 Status=0, data=0x000000, PAUSE_EN=0 -> CRC=5; pulse widths 56,12x7,17; total 157 ticks; frame_done on tick 157.
REQ-030 Same frame with PAUSE_EN=1 -> pause pulse 125 ticks (5 low); frame_done on tick 282.
REQ-031 Status=0xF, data=0xFFFFFF, PAUSE_EN=1 -> CRC=10; widths 56,27x7,22; pause 15; total 282.
REQ-032 Second frame_valid held high during busy -> frame_ready=0, no capture; accepted the cycle after frame_done; new sync starts on the next tick_en.
REQ-033 reset_n_tx pulsed during D3 -> sent_out=1, busy=0 the same cycle; no pulses until a new capture.
REQ-034 tick_en spacing randomized between 1 and 7 clocks -> tick-count widths identical to REQ-029.
